counter_cmd_seq: RTL

COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

---
 rtl/counter_cmd_seq_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/counter_cmd_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/counter_cmd_seq_pkg.sv
// Shared definitions for the command sequencer: counter mode codes and FSM states.
`ifndef COUNTER_CMD_SEQ_PKG_SV
`define COUNTER_CMD_SEQ_PKG_SV

package counter_cmd_seq_pkg;

    // Counter mode codes understood by the downstream counter
    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer states: waiting for work, or executing a command
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

`endif

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO with registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer: queues {mode, data, len} commands and plays each one onto
// the counter control lines for len+1 cycles, chaining queued commands with no gap.
module counter_cmd_seq
    import counter_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [3:0]               cmd_data,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     enable,
    output logic [1:0]               mode,
    output logic [3:0]               D,
    output logic                     last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int FW = 2 + 4 + LEN_W;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             enable_next;
    logic [1:0]       mode_next;
    logic [3:0]       d_next;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] remain_next;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_head;
    logic [1:0]       head_mode;
    logic [3:0]       head_data;
    logic [LEN_W-1:0] head_len;

    // Ready depends only on the registered FIFO count, never on cmd_valid
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign {head_mode, head_data, head_len} = fifo_head;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push),
        .push_data ({cmd_mode, cmd_data, cmd_len}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy = (state == ST_RUN);
    assign last = (state == ST_RUN) && (remain == '0);

    // Next-state decode: pop and load when idle or finishing, otherwise count down
    always_comb begin
        state_next  = state;
        enable_next = enable;
        mode_next   = mode;
        d_next      = D;
        remain_next = remain;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_next  = ST_RUN;
                    enable_next = 1'b1;
                    mode_next   = head_mode;
                    d_next      = head_data;
                    remain_next = head_len;
                end
            end
            ST_RUN: begin
                if (remain == '0) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        enable_next = 1'b1;
                        mode_next   = head_mode;
                        d_next      = head_data;
                        remain_next = head_len;
                    end else begin
                        state_next  = ST_IDLE;
                        enable_next = 1'b0;
                        mode_next   = MODE_UP3;
                        d_next      = 4'h0;
                        remain_next = '0;
                    end
                end else begin
                    remain_next = remain - LEN_ONE;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                enable_next = 1'b0;
                mode_next   = MODE_UP3;
                d_next      = 4'h0;
                remain_next = '0;
            end
        endcase
    end

    // State and counter-control registers; reset drops everything to idle at once
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= ST_IDLE;
            enable <= 1'b0;
            mode   <= MODE_UP3;
            D      <= 4'h0;
            remain <= '0;
        end else begin
            state  <= state_next;
            enable <= enable_next;
            mode   <= mode_next;
            D      <= d_next;
            remain <= remain_next;
        end
    end

endmodule
